// File: rtl/spi_mem_ctrl_pkg.sv
// Shared definitions for the SPI serial-memory controller: opcodes, FSM states, port encodings.
package spi_mem_ctrl_pkg;

    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE = 8'h02;

    // One-hot requester encoding shared by the arbiter and the top level
    localparam logic [1:0] PORT_A = 2'b01;
    localparam logic [1:0] PORT_B = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    function automatic logic [7:0] spi_opcode(input logic we);
        return we ? SPI_OP_WRITE : SPI_OP_READ;
    endfunction

endpackage

// File: rtl/spi_mem_ctrl_arb.sv
// Two-way round-robin arbiter. Grant is combinational; the last-grant flop is
// updated only when the owner accepts a grant, and stays valid for the whole
// transaction so the top level can use it as "who owns the bus".
module rr_arb2
    import spi_mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o,
    output logic [1:0] last_gnt_o
);

    logic [1:0] last_q, last_d;

    // Grant selection: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = PORT_A;
            2'b10:   gnt_o = PORT_B;
            2'b11:   gnt_o = (last_q == PORT_B) ? PORT_A : PORT_B;
            default: gnt_o = 2'b00;
        endcase
        last_d = (update_i && (gnt_o != 2'b00)) ? gnt_o : last_q;
    end

    // Last-grant register; B counts as last after reset so A wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= PORT_B;
        else        last_q <= last_d;
    end

    assign last_gnt_o = last_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI serial-memory controller: turns single-byte read/write requests from an
// instruction port (A, read-only) and a data port (B) into opcode/address/data
// byte sequences on a shared SPI byte core, and owns the memory chip select.
module spi_mem_ctrl
    import spi_mem_ctrl_pkg::*;
#(
    parameter  int ADDR_BYTES = 2,
    parameter  int CS_SETUP   = 2,
    parameter  int CS_HOLD    = 2,
    localparam int AW         = 8 * ADDR_BYTES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req_i,
    input  logic [AW-1:0] a_addr_i,
    output logic          a_ack_o,
    output logic [7:0]    a_rdata_o,
    input  logic          b_req_i,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [7:0]    b_wdata_i,
    output logic          b_ack_o,
    output logic [7:0]    b_rdata_o,
    output logic          busy_o,
    output logic          spi_cs_n_o,
    output logic [7:0]    core_data_tx_o,
    output logic          core_txn_start_o,
    input  logic          core_txn_done_i,
    input  logic [7:0]    core_data_rx_i
);

    localparam int NBYTES     = ADDR_BYTES + 2;
    localparam int IW         = $clog2(NBYTES);
    localparam int CW         = 8;
    // Counters run down to zero, so load one less than the cycle count; a
    // zero setup still spends one pass-through cycle, hold is at least one.
    localparam int SETUP_LOAD = (CS_SETUP > 1) ? CS_SETUP - 1 : 0;
    localparam int HOLD_LOAD  = (CS_HOLD > 1) ? CS_HOLD - 1 : 0;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            cs_n_q, cs_n_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      a_rdata_q, a_rdata_d;
    logic [7:0]      b_rdata_q, b_rdata_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;

    logic [1:0]      gnt;
    logic [1:0]      last_gnt;
    logic            owner_b;
    logic            is_last;
    logic [7:0]      byte_sel;
    logic            ack_a, ack_b;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      ({b_req_i, a_req_i}),
        .update_i   (state_q == ST_IDLE),
        .gnt_o      (gnt),
        .last_gnt_o (last_gnt)
    );

    // The arbiter's last grant is the current owner for the whole transaction
    assign owner_b = last_gnt[1];
    assign is_last = (idx_q == IW'(NBYTES - 1));

    // Byte for the current index: opcode, address MSB first, then data/dummy
    always_comb begin
        byte_sel = 8'h00;
        if (idx_q == '0) byte_sel = spi_opcode(we_q);
        for (int i = 0; i < ADDR_BYTES; i++) begin
            if (idx_q == IW'(i + 1)) byte_sel = addr_q[AW-1-8*i -: 8];
        end
        if (is_last && we_q) byte_sel = wdata_q;
    end

    // Transaction sequencer: grant, CS setup, per-byte start/wait, CS hold, ack
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        start_d   = 1'b0;
        tx_d      = tx_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_a     = 1'b0;
        ack_b     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    we_d    = gnt[1] ? b_we_i : 1'b0;
                    addr_d  = gnt[1] ? b_addr_i : a_addr_i;
                    wdata_d = b_wdata_i;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    cnt_d   = CW'(SETUP_LOAD);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) state_d = ST_START;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_START: begin
                if (core_txn_done_i) begin
                    start_d = 1'b1;
                    tx_d    = byte_sel;
                    first_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The core's done flag still reads idle in the strobe cycle
                first_d = 1'b0;
                if (!first_q && core_txn_done_i) begin
                    if (is_last) begin
                        if (!we_q) begin
                            if (owner_b) b_rdata_d = core_data_rx_i;
                            else         a_rdata_d = core_data_rx_i;
                        end
                        cs_n_d  = 1'b1;
                        cnt_d   = CW'(HOLD_LOAD);
                        state_d = ST_HOLD;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_START;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    ack_a   = !owner_b;
                    ack_b   = owner_b;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            tx_q      <= 8'h00;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            tx_q      <= tx_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign a_ack_o          = ack_a;
    assign b_ack_o          = ack_b;
    assign a_rdata_o        = a_rdata_q;
    assign b_rdata_o        = b_rdata_q;
    assign busy_o           = busy_q;
    assign spi_cs_n_o       = cs_n_q;
    assign core_data_tx_o   = tx_q;
    assign core_txn_start_o = start_q;

endmodule
